// File: rtl/muldiv_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit: command codes,
// FSM state encoding, datapath width and the muldiv command decode.
// Optional divider build: EXE_MULDIV_DIV_EN.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 5;

  // Codes reserved in the ALU decode for the iterative unit
  localparam logic [3:0] EXE_MUL = 4'b1100;
  localparam logic [3:0] EXE_DIV = 4'b1101;
  localparam logic [3:0] EXE_REM = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // True for commands this unit executes; DIV/REM only when the divider is built
  function automatic logic is_muldiv_cmd(input logic [3:0] cmd);
`ifdef EXE_MULDIV_DIV_EN
    return (cmd == EXE_MUL) || (cmd == EXE_DIV) || (cmd == EXE_REM);
`else
    return (cmd == EXE_MUL);
`endif
  endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Control for the iterative multiply/divide unit: IDLE/BUSY/DONE state,
// 5-bit iteration counter, pipeline stall, busy flag and flush handling.
module muldiv_fsm
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic flush,
  output logic start,
  output logic step,
  output logic last,
  output logic stall,
  output logic busy
);

  md_state_e          state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               busy_reg;

  // State, counter and registered busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == BUSY);
    end
  end

  // Next state and control strobes; flush beats issue and iteration
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start      = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req && !flush) begin
          start      = 1'b1;
          stall      = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (flush) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          step     = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(ITERS - 1)) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        // Result is already committed; the held instruction leaves on this edge
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = busy_reg;

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage iterative multiply/divide unit: 32-cycle shift-add multiply and,
// when EXE_MULDIV_DIV_EN is defined, restoring divide/remainder on magnitudes
// with sign fix-up. Holds the pipeline via stall while working.
module exe_muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      EXE_CMD_IN,
  input  logic [XLEN-1:0] val1In,
  input  logic [XLEN-1:0] val2In,
  input  logic [4:0]      destIn,
  input  logic            WB_EN_IN,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest,
  output logic            WB_EN,
  output logic            busy
);

  logic req, start, step, last;

  assign req = is_muldiv_cmd(EXE_CMD_IN);

  muldiv_fsm u_fsm (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .flush (flush),
    .start (start),
    .step  (step),
    .last  (last),
    .stall (stall),
    .busy  (busy)
  );

  // acc: product accumulator / partial remainder
  // a:   multiplicand / dividend shifting into quotient
  // b:   multiplier / divisor magnitude
  logic [XLEN-1:0] acc_reg, a_reg, b_reg;
  logic [XLEN-1:0] acc_next, a_next, b_next, final_value;
  logic [4:0]      dest_lat_reg;
  logic            wb_lat_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      dest_reg;
  logic            wb_en_reg;

`ifdef EXE_MULDIV_DIV_EN
  logic            div_mode_reg, rem_mode_reg, sign_dvd_reg, sign_quo_reg, dbz_reg;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] mag1, mag2, quo_fix, rem_fix;

  assign mag1    = val1In[XLEN-1] ? -val1In : val1In;
  assign mag2    = val2In[XLEN-1] ? -val2In : val2In;
  assign shifted = {acc_reg, a_reg[XLEN-1]};
  assign trial   = shifted - {1'b0, b_reg};
`endif

  // One iteration of the selected algorithm
  always_comb begin
    acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
    a_next   = {a_reg[XLEN-2:0], 1'b0};
    b_next   = {1'b0, b_reg[XLEN-1:1]};
`ifdef EXE_MULDIV_DIV_EN
    if (div_mode_reg) begin
      b_next = b_reg;
      if (!trial[XLEN]) begin
        acc_next = trial[XLEN-1:0];
        a_next   = {a_reg[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        a_next   = {a_reg[XLEN-2:0], 1'b0};
      end
    end
`endif
  end

  // Final value from the last iteration, with divide sign and zero-divisor handling
  always_comb begin
    final_value = acc_next;
`ifdef EXE_MULDIV_DIV_EN
    quo_fix = dbz_reg ? '1 : (sign_quo_reg ? -a_next : a_next);
    rem_fix = sign_dvd_reg ? -acc_next : acc_next;
    if (div_mode_reg) begin
      final_value = rem_mode_reg ? rem_fix : quo_fix;
    end
`endif
  end

  // Operand latch, iteration registers and registered completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      dest_lat_reg <= '0;
      wb_lat_reg   <= 1'b0;
      result_reg   <= '0;
      dest_reg     <= '0;
      wb_en_reg    <= 1'b0;
`ifdef EXE_MULDIV_DIV_EN
      div_mode_reg <= 1'b0;
      rem_mode_reg <= 1'b0;
      sign_dvd_reg <= 1'b0;
      sign_quo_reg <= 1'b0;
      dbz_reg      <= 1'b0;
`endif
    end else begin
      wb_en_reg <= 1'b0;
      if (start) begin
        acc_reg      <= '0;
        a_reg        <= val1In;
        b_reg        <= val2In;
        dest_lat_reg <= destIn;
        wb_lat_reg   <= WB_EN_IN;
`ifdef EXE_MULDIV_DIV_EN
        div_mode_reg <= (EXE_CMD_IN != EXE_MUL);
        rem_mode_reg <= (EXE_CMD_IN == EXE_REM);
        sign_dvd_reg <= val1In[XLEN-1];
        sign_quo_reg <= val1In[XLEN-1] ^ val2In[XLEN-1];
        dbz_reg      <= (val2In == '0);
        if (EXE_CMD_IN != EXE_MUL) begin
          a_reg <= mag1;
          b_reg <= mag2;
        end
`endif
      end else if (step) begin
        acc_reg <= acc_next;
        a_reg   <= a_next;
        b_reg   <= b_next;
      end
      if (last) begin
        result_reg <= final_value;
        dest_reg   <= dest_lat_reg;
        wb_en_reg  <= wb_lat_reg;
      end
    end
  end

  assign result = result_reg;
  assign dest   = dest_reg;
  assign WB_EN  = wb_en_reg;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed test-plan cases plus randomized
// instruction streams, checked every cycle against a timeline model.
module tb_exe_muldiv;

  localparam logic [3:0] C_MUL = 4'b1100;
  localparam logic [3:0] C_DIV = 4'b1101;
  localparam logic [3:0] C_REM = 4'b1110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  EXE_CMD_IN = 4'd0;
  logic [31:0] val1In = 32'd0;
  logic [31:0] val2In = 32'd0;
  logic [4:0]  destIn = 5'd0;
  logic        WB_EN_IN = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] result;
  logic [4:0]  dest;
  logic        WB_EN;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exe_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .EXE_CMD_IN (EXE_CMD_IN),
    .val1In     (val1In),
    .val2In     (val2In),
    .destIn     (destIn),
    .WB_EN_IN   (WB_EN_IN),
    .flush      (flush),
    .stall      (stall),
    .result     (result),
    .dest       (dest),
    .WB_EN      (WB_EN),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Commands the unit accepts in this build
  function automatic bit md(input logic [3:0] c);
`ifdef EXE_MULDIV_DIV_EN
    return (c == C_MUL) || (c == C_DIV) || (c == C_REM);
`else
    return (c == C_MUL);
`endif
  endfunction

  // Architectural result of a command
  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (c == C_MUL) return a * b;
    if (c == C_DIV) begin
      if (b == 32'd0) return 32'hFFFFFFFF;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
      return sa / sb;
    end
    if (b == 32'd0) return a;
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
    return sa % sb;
  endfunction

  // Model: an accepted op at cycle t stalls t..t+32, is busy t+1..t+32, completes at t+33
  bit          m_active = 0;
  int          m_t0 = 0;
  logic [31:0] m_lres = 0, m_res = 0;
  logic [4:0]  m_ldest = 0, m_dest = 0;
  logic        m_lwb = 0;
  int          wb_cnt = 0;
  int          obs_wb_cyc = 0;
  logic [31:0] obs_wb_res = 0;
  logic [4:0]  obs_wb_dest = 0;

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    int k;
    logic e_stall, e_busy, e_wb;
    e_stall = 1'b0;
    e_busy  = 1'b0;
    e_wb    = 1'b0;
    if (!rst) begin
      m_active = 0;
      m_res    = 32'd0;
      m_dest   = 5'd0;
      e_stall  = md(EXE_CMD_IN) && !flush;
    end else begin
      k = m_active ? (cyc - m_t0) : 0;
      if (!m_active) begin
        e_stall = md(EXE_CMD_IN) && !flush;
        if (e_stall) begin
          m_active = 1;
          m_t0     = cyc;
          m_lres   = ref_res(EXE_CMD_IN, val1In, val2In);
          m_ldest  = destIn;
          m_lwb    = WB_EN_IN;
        end
      end else if (k <= 32) begin
        e_stall = 1'b1;
        e_busy  = 1'b1;
        if (flush) m_active = 0;
      end else begin
        m_res    = m_lres;
        m_dest   = m_ldest;
        e_wb     = m_lwb;
        m_active = 0;
      end
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("wb_en", 32'(WB_EN), 32'(e_wb));
    chk("result", result, m_res);
    chk("dest", 32'(dest), 32'(m_dest));
    if (WB_EN === 1'b1) begin
      wb_cnt++;
      obs_wb_cyc  = cyc;
      obs_wb_res  = result;
      obs_wb_dest = dest;
    end
  end

  // Present one instruction in ID/EXE and hold it until the pipeline accepts it
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic w, input bit rnd_flush,
                        output int n, output int t);
    bit s, f;
    EXE_CMD_IN = c;
    val1In     = a;
    val2In     = b;
    destIn     = d;
    WB_EN_IN   = w;
    t = cyc;
    n = 0;
    forever begin
      f = rnd_flush && ($urandom_range(0, 49) == 0);
      flush = f;
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      n++;
      flush = 1'b0;
      if (!s || f) break;
      if (n > 200) begin
        chk("op_timeout", 32'(n), 32'd34);
        break;
      end
    end
    $display("op cmd=%h a=%h b=%h dest=%0d wb=%0d held=%0d flushed=%0d", c, a, b, d, w, n, f);
    EXE_CMD_IN = 4'd0;
  endtask

  task automatic directed(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp);
    int n, t, w0;
    w0 = wb_cnt;
    run_op(c, a, b, d, 1'b1, 1'b0, n, t);
    chk({name, "_held"}, 32'(n), 32'd34);
    chk({name, "_wbcnt"}, 32'(wb_cnt - w0), 32'd1);
    chk({name, "_res"}, obs_wb_res, exp);
    chk({name, "_dest"}, 32'(obs_wb_dest), 32'(d));
    chk({name, "_lat"}, 32'(obs_wb_cyc - t), 32'd33);
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] sp [5];
    sp[0] = 32'd0;
    sp[1] = 32'd1;
    sp[2] = 32'hFFFFFFFF;
    sp[3] = 32'h80000000;
    sp[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 200)) - 32'd100;
    return $urandom;
  endfunction

  initial begin
    int n, t, w0;
    logic [3:0] c;

    // Pin the reference model to hand-computed values
    chk("model_mul", ref_res(C_MUL, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_div", ref_res(C_DIV, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("model_rem", ref_res(C_REM, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    chk("model_rem2", ref_res(C_REM, 32'd7, 32'hFFFFFFFE), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_wb", 32'(WB_EN), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // MUL with negative multiplier, then an ADD straight behind it
    directed("mul_neg", C_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
    run_op(4'd0, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0, n, t);
    chk("add_after_mul_held", 32'(n), 32'd1);

`ifdef EXE_MULDIV_DIV_EN
    directed("div_neg", C_DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD);
    directed("rem_neg", C_REM, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF);
    directed("rem_negdiv", C_REM, 32'd7, 32'hFFFFFFFE, 5'd8, 32'd1);
    directed("div_zero", C_DIV, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF);
    directed("rem_zero", C_REM, 32'd5, 32'd0, 5'd10, 32'd5);
    directed("div_ovf", C_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
    directed("rem_ovf", C_REM, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0);
`else
    w0 = wb_cnt;
    run_op(C_DIV, 32'd5, 32'd2, 5'd6, 1'b1, 1'b0, n, t);
    chk("div_off_held", 32'(n), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("div_off_wbcnt", 32'(wb_cnt - w0), 32'd0);
`endif

    // Reset asserted ten cycles into an operation
    EXE_CMD_IN = C_MUL;
    val1In     = 32'd9;
    val2In     = 32'd9;
    destIn     = 5'd4;
    WB_EN_IN   = 1'b1;
    w0 = wb_cnt;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    EXE_CMD_IN = 4'd0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    directed("mul_after_rst", C_MUL, 32'd3, 32'd4, 5'd13, 32'd12);
    chk("midrst_wbcnt", 32'(wb_cnt - w0), 32'd1);

    // Flush five cycles into an operation
    w0 = wb_cnt;
    EXE_CMD_IN = C_MUL;
    val1In     = 32'd11;
    val2In     = 32'd13;
    destIn     = 5'd14;
    WB_EN_IN   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    EXE_CMD_IN = 4'd0;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_wbcnt", 32'(wb_cnt - w0), 32'd0);

    // MUL without write-back still completes with full latency
    w0 = wb_cnt;
    run_op(C_MUL, 32'd3, 32'd4, 5'd15, 1'b0, 1'b0, n, t);
    chk("mul_nowb_held", 32'(n), 32'd34);
    chk("mul_nowb_wbcnt", 32'(wb_cnt - w0), 32'd0);
    chk("mul_nowb_res", result, 32'd12);
    chk("mul_nowb_dest", 32'(dest), 32'd15);

    // Randomized instruction stream with occasional flushes and bubbles
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = C_MUL;
        4, 5:       c = C_DIV;
        6, 7:       c = C_REM;
        8:          c = 4'd0;
        default:    c = 4'($urandom_range(0, 11));
      endcase
      run_op(c, pick_val(), pick_val(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, n, t);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit in the EXE stage, fed by the ID-to-EXE pipeline register outputs (EXE_CMD, val1, val2, dest, WB_EN). It executes MUL, DIV and REM over 32 iterations. While busy it asserts `stall`, which freezes PC, IF/ID and ID/EXE so the issuing instruction is held. On completion it presents a registered result with its dest/WB_EN for the EXE-to-MEM register.

## Interface
- No parameters; operand width fixed at 32, iteration count fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- EXE_CMD_IN  in  4  command from ID/EXE register
- val1In  in  32  operand 1 (multiplicand / dividend)
- val2In  in  32  operand 2 (multiplier / divisor)
- destIn  in  5  destination register
- WB_EN_IN  in  1  write-back enable of the issuing instruction
- flush  in  1  abort in-flight operation (branch taken)
- stall  out  1  combinational; freezes upstream pipeline
- result  out  32  registered result
- dest  out  5  registered destination
- WB_EN  out  1  registered one-cycle completion/write-back strobe
- busy  out  1  registered, high in BUSY

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if EXE_CMD_IN ∈ {MUL, DIV, REM} and flush=0 → latch operands, cmd, destIn, WB_EN_IN; clear counter; → BUSY. Other commands are ignored.
- BUSY: one iteration per cycle, counter 0..31; when counter=31 → DONE. flush=1 → IDLE, no write-back.
- DONE: result/dest registered, WB_EN=1 (only if latched WB_EN_IN=1); inputs ignored; → IDLE unconditionally.
- stall = (IDLE & muldiv cmd & ~flush) | BUSY. Low in DONE, so the held instruction leaves ID/EXE on the edge ending DONE, and is never re-issued.
- MUL: shift-add on raw operands; result = low 32 bits of product (signed/unsigned identical).
- DIV/REM: restoring division on magnitudes. Quotient sign = sign1 ^ sign2; remainder sign = sign of dividend.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend; full latency.
- Overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- result and dest hold their last values until the next DONE.

## Timing
- Issue cycle T (IDLE, cmd present): stall=1 combinationally.
- BUSY in cycles T+1..T+32; DONE in T+33 with WB_EN=1 and stall=0.
- Stall covers 33 cycles (T..T+32). Next instruction enters ID/EXE at the edge ending T+33.
- Reset values: state IDLE, result 0, dest 0, WB_EN 0, busy 0, counter 0; stall is 0 unless a muldiv cmd is present.
- Reset assertion mid-operation: immediate IDLE, WB_EN never pulses for the aborted operation.
- flush takes priority over issue in IDLE and over iteration in BUSY; flush in DONE is ignored (result already committed).

## Configuration
- `EXE_MULDIV_DIV_EN` defined: DIV and REM decoded and executed as above.
- Not defined: divider datapath omitted. DIV/REM are not muldiv commands: stall never rises for them, the unit stays IDLE, and no WB_EN is issued. MUL behaviour is unchanged.

## Structure
- Shared package `muldiv_pkg`: EXE_CMD codes EXE_MUL=4'b1100, EXE_DIV=4'b1101, EXE_REM=4'b1110 (reserved in the ALU decode); state encoding IDLE/BUSY/DONE; width constant 32.
- One sub-module: `muldiv_fsm` holds the state, the 5-bit counter, stall/busy generation and flush handling. The datapath (accumulator, shift registers, sign fix-up) stays in `exe_muldiv`.

## Test plan
- MUL val1=7, val2=0xFFFFFFFD, dest=5, WB_EN_IN=1 → stall high T..T+32; WB_EN pulses at T+33 with result 0xFFFFFFEB and dest 5.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; REM 7 / 0xFFFFFFFE → 1.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Reset asserted at T+10 → stall and busy 0 immediately, no WB_EN; a following MUL 3*4 → 12 with full latency.
- flush at T+5 → IDLE at T+6, stall 0, no WB_EN; MUL with WB_EN_IN=0 → completes with WB_EN=0 at T+33.
- Back-to-back MUL then ADD (cmd 0) → ADD enters EXE after DONE with no extra stall. Build without macro: DIV cmd → stall stays 0, no WB_EN.
